demux_8_buffered: RTL and testbench

//  Inverse of the 8-way 32-bit select mux: routes one 32-bit input word to one of

---
 rtl/demux_8_buffered_pkg.sv | 22 ++
 rtl/demux_channel.sv | 40 ++++
 rtl/demux_8_buffered.sv | 81 ++++++++
 tb/tb_demux_8_buffered.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/demux_8_buffered_pkg.sv
// demux_8_buffered_pkg: shared constants and the channel-select decoder for the buffered 8-way demux.
//   DEMUX_NUM_CH  number of output channels
//   DEMUX_SEL_W   width of the channel select
//   DEMUX_WIDTH   data width of the input word and each channel register
//   demux_decode  one-hot channel mask for a select, or all ones on broadcast
package demux_8_buffered_pkg;

    localparam int DEMUX_NUM_CH = 8;
    localparam int DEMUX_SEL_W  = 3;
    localparam int DEMUX_WIDTH  = 32;

    function automatic logic [DEMUX_NUM_CH-1:0] demux_decode(
        input logic [DEMUX_SEL_W-1:0] sel,
        input logic                   bcast
    );
        logic [DEMUX_NUM_CH-1:0] mask;
        mask      = '0;
        mask[sel] = 1'b1;
        return bcast ? {DEMUX_NUM_CH{1'b1}} : mask;
    endfunction

endpackage

// File: rtl/demux_channel.sv
// demux_channel: one 1-deep output register with a valid/ready handshake.
//   clock        rising-edge clock
//   reset        asynchronous active-high clear of data and valid
//   load         write load_data this edge (only asserted by the top when free)
//   load_data    word to capture
//   drain_ready  consumer takes the held word this cycle
//   data         held word (kept after a drain)
//   valid        data holds an unconsumed word
//   free         channel is empty or draining this cycle
module demux_channel
    import demux_8_buffered_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             drain_ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             free
);

    assign free = ~valid | drain_ready;

    // A load on the same edge as a drain wins, keeping valid high for full throughput.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            valid <= 1'b1;
        end else if (drain_ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_8_buffered.sv
// demux_8_buffered: routes one word to one of eight buffered channels, or to all of them on broadcast.
//   clock       rising-edge clock
//   reset       asynchronous active-high clear of all state
//   in_data     word to route
//   in_select   destination channel index
//   in_bcast    write every channel, in_select ignored
//   in_valid    producer has a word
//   in_ready    word can be accepted this cycle (combinational from out_ready/select/bcast)
//   out0..out7  channel data registers
//   out_valid   per-channel unconsumed-word flags
//   out_ready   per-channel consumer take strobes
//   xfer_count  accepted input words, broadcast counts once, wraps
module demux_8_buffered
    import demux_8_buffered_pkg::*;
#(
    parameter int WIDTH  = DEMUX_WIDTH,
    parameter int NUM_CH = DEMUX_NUM_CH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [DEMUX_SEL_W-1:0] in_select,
    input  logic                   in_bcast,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       out0,
    output logic [WIDTH-1:0]       out1,
    output logic [WIDTH-1:0]       out2,
    output logic [WIDTH-1:0]       out3,
    output logic [WIDTH-1:0]       out4,
    output logic [WIDTH-1:0]       out5,
    output logic [WIDTH-1:0]       out6,
    output logic [WIDTH-1:0]       out7,
    output logic [NUM_CH-1:0]      out_valid,
    input  logic [NUM_CH-1:0]      out_ready,
    output logic [31:0]            xfer_count
);

    logic [NUM_CH-1:0] target;
    logic [NUM_CH-1:0] free;
    logic [NUM_CH-1:0] load;
    logic              accept;
    logic [WIDTH-1:0]  ch_data [NUM_CH];

    assign target   = demux_decode(in_select, in_bcast);
    // Broadcast needs every channel to take the word on the same edge.
    assign in_ready = in_bcast ? &free : free[in_select];
    assign accept   = in_valid & in_ready;
    assign load     = {NUM_CH{accept}} & target;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        demux_channel #(.WIDTH(WIDTH)) u_ch (
            .clock       (clock),
            .reset       (reset),
            .load        (load[i]),
            .load_data   (in_data),
            .drain_ready (out_ready[i]),
            .data        (ch_data[i]),
            .valid       (out_valid[i]),
            .free        (free[i])
        );
    end

    assign out0 = ch_data[0];
    assign out1 = ch_data[1];
    assign out2 = ch_data[2];
    assign out3 = ch_data[3];
    assign out4 = ch_data[4];
    assign out5 = ch_data[5];
    assign out6 = ch_data[6];
    assign out7 = ch_data[7];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            xfer_count <= '0;
        end else if (accept) begin
            xfer_count <= xfer_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_demux_8_buffered.sv
// tb_demux_8_buffered: scoreboard bench with per-channel expected-word queues and a negedge monitor.
module tb_demux_8_buffered;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] in_data = '0;
    logic [2:0]  in_select = '0;
    logic        in_bcast = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out0, out1, out2, out3, out4, out5, out6, out7;
    logic [7:0]  out_valid;
    logic [7:0]  out_ready = '0;
    logic [31:0] xfer_count;
    logic [31:0] outs [8];

    int n_pass = 0;
    int n_total = 0;

    // Reference model: each channel is a queue of words the DUT should be holding.
    logic [31:0] q [8][$];
    logic [31:0] exp_cnt = '0;
    logic        pend_acc = 1'b0;
    logic [7:0]  pend_mask = '0;
    logic [31:0] pend_data = '0;
    logic        mon_en = 1'b0;

    always #5 clock = ~clock;

    demux_8_buffered dut (
        .clock      (clock),
        .reset      (reset),
        .in_data    (in_data),
        .in_select  (in_select),
        .in_bcast   (in_bcast),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0       (out0),
        .out1       (out1),
        .out2       (out2),
        .out3       (out3),
        .out4       (out4),
        .out5       (out5),
        .out6       (out6),
        .out7       (out7),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .xfer_count (xfer_count)
    );

    assign outs[0] = out0;
    assign outs[1] = out1;
    assign outs[2] = out2;
    assign outs[3] = out3;
    assign outs[4] = out4;
    assign outs[5] = out5;
    assign outs[6] = out6;
    assign outs[7] = out7;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One clock of stimulus: commit last cycle's accept into the model, drive, predict in_ready.
    task automatic step(input logic [31:0] d, input logic [2:0] s, input logic b, input logic v,
                        input logic [7:0] r);
        logic [7:0] fr;
        logic       er;
        @(posedge clock);
        #1;
        if (pend_acc) begin
            for (int k = 0; k < 8; k++) if (pend_mask[k]) q[k].push_back(pend_data);
            exp_cnt = exp_cnt + 32'd1;
        end
        in_data   = d;
        in_select = s;
        in_bcast  = b;
        in_valid  = v;
        out_ready = r;
        for (int k = 0; k < 8; k++) fr[k] = (q[k].size() == 0) || r[k];
        er        = b ? (fr == 8'hFF) : fr[s];
        pend_acc  = v && er;
        pend_mask = b ? 8'hFF : 8'(1 << s);
        pend_data = d;
        #1;
        chk("in_ready", {31'd0, in_ready}, {31'd0, er});
    endtask

    task automatic idle();
        step(32'h0, 3'd0, 1'b0, 1'b0, 8'h00);
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            for (int k = 0; k < 8; k++) begin
                chk($sformatf("out_valid[%0d]", k), {31'd0, out_valid[k]}, {31'd0, q[k].size() != 0});
                if (out_valid[k] && q[k].size() != 0) begin
                    chk($sformatf("out%0d", k), outs[k], q[k][0]);
                    if (out_ready[k]) void'(q[k].pop_front());
                end
            end
            chk("xfer_count", xfer_count, exp_cnt);
        end
    end

    initial begin
        #12;
        chk("reset out_valid", {24'd0, out_valid}, 32'h0);
        chk("reset xfer_count", xfer_count, 32'h0);
        reset = 1'b0;
        mon_en = 1'b1;
        idle();

        // Single route to channel 5.
        step(32'hDEADBEEF, 3'd5, 1'b0, 1'b1, 8'h00);
        idle();
        chk("route out5", out5, 32'hDEADBEEF);
        chk("route out_valid", {24'd0, out_valid}, 32'h20);
        chk("route count", xfer_count, 32'd1);

        // Backpressure on full channel 5, other channel still accepts.
        step(32'h5555_0000, 3'd5, 1'b0, 1'b1, 8'h00);
        chk("bp ready5", {31'd0, in_ready}, 32'd0);
        step(32'h2222_2222, 3'd2, 1'b0, 1'b1, 8'h00);
        chk("bp ready2", {31'd0, in_ready}, 32'd1);
        idle();
        chk("bp out5 held", out5, 32'hDEADBEEF);
        chk("bp out2", out2, 32'h2222_2222);

        // Same-cycle drain and reload on channel 3, streamed for 8 cycles.
        step(32'h3333_3333, 3'd3, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 8; i++) begin
            step(32'h1, 3'd3, 1'b0, 1'b1, 8'h08);
            chk("stream ready", {31'd0, in_ready}, 32'd1);
        end
        idle();
        chk("stream out3", out3, 32'h1);
        chk("stream valid3", {31'd0, out_valid[3]}, 32'd1);
        chk("stream count", xfer_count, 32'd11);

        // Broadcast blocked by a full channel, then accepted once all are free.
        step(32'h6666_6666, 3'd6, 1'b0, 1'b1, 8'h00);
        step(32'hA5A5A5A5, 3'd0, 1'b1, 1'b1, 8'h00);
        chk("bcast blocked", {31'd0, in_ready}, 32'd0);
        step(32'hA5A5A5A5, 3'd1, 1'b1, 1'b1, 8'hFF);
        chk("bcast ready", {31'd0, in_ready}, 32'd1);
        idle();
        chk("bcast out_valid", {24'd0, out_valid}, 32'hFF);
        for (int k = 0; k < 8; k++) chk($sformatf("bcast out%0d", k), outs[k], 32'hA5A5A5A5);
        chk("bcast count", xfer_count, 32'd13);

        // Asynchronous reset in mid-cycle with every channel full.
        idle();
        #1 reset = 1'b1;
        #1;
        chk("areset out_valid", {24'd0, out_valid}, 32'h0);
        chk("areset count", xfer_count, 32'h0);
        for (int k = 0; k < 8; k++) chk($sformatf("areset out%0d", k), outs[k], 32'h0);
        chk("areset ready", {31'd0, in_ready}, 32'd1);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) q[k].delete();
        exp_cnt = '0;
        pend_acc = 1'b0;

        // Counter wrap.
        idle();
        #1 force dut.xfer_count = 32'hFFFF_FFFF;
        #1 release dut.xfer_count;
        exp_cnt = 32'hFFFF_FFFF;
        step(32'h0BAD_F00D, 3'd4, 1'b0, 1'b1, 8'hFF);
        idle();
        chk("wrap count", xfer_count, 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++)
            step($urandom, 3'($urandom_range(0, 7)), $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) != 0, 8'($urandom));
        for (int i = 0; i < 3; i++) step(32'h0, 3'd0, 1'b0, 1'b0, 8'hFF);
        @(posedge clock);
        #1 mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
